seg7_scan_ctrl: RTL

Time-multiplexed scan controller for the stopwatch's 4-digit 7-segment display. Cycles a 2-bit digit index that drives the digit-select decoder, and presents the matching BCD digit and decimal point to the segment encoder. Adds anti-ghosting dead time, leading-zero blanking and double-buffered value loading, so the stopwatch counter can update the display without tearing mid-frame.

---
 rtl/seg7_scan_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with dead time,
// leading-zero blanking and a frame-synchronous double-buffered display value.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500,
  parameter int CNT_W       = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_lzb,
  output logic [1:0]  o_sel,
  output logic [3:0]  o_bcd,
  output logic        o_dp,
  output logic        o_blank,
  output logic        o_frame
);

  localparam logic [CNT_W-1:0] TC   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD = CNT_W'(DEAD_CYCLES);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       idx, idx_n;
  logic [15:0]      pend_val, act_val, act_n;
  logic [3:0]       pend_dp, act_dp, act_dp_n;
  logic             pend_flag;
  logic             wrap, xfer, lz, blank_n;
  logic [3:0]       digit;

  // Outputs are registered from next-state values so sel/bcd/dp/blank
  // always describe the slot the counters are entering, with no skew.
  always_comb begin
    wrap  = i_en && (cnt == TC) && (idx == 2'd3);
    xfer  = pend_flag && (wrap || !i_en);
    cnt_n = '0;
    idx_n = '0;
    if (i_en) begin
      if (cnt == TC) begin
        cnt_n = '0;
        idx_n = idx + 2'd1;
      end else begin
        cnt_n = cnt + 1'b1;
        idx_n = idx;
      end
    end
    act_n    = xfer ? pend_val : act_val;
    act_dp_n = xfer ? pend_dp  : act_dp;
    digit    = act_n[{idx_n, 2'b00} +: 4];
    case (idx_n)
      2'd3:    lz = (act_n[15:12] == 4'd0);
      2'd2:    lz = (act_n[15:8]  == 8'd0);
      2'd1:    lz = (act_n[15:4]  == 12'd0);
      default: lz = 1'b0;
    endcase
    blank_n = !i_en || (cnt_n < DEAD) || (i_lzb && lz);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      act_val   <= '0;
      act_dp    <= '0;
      o_sel     <= '0;
      o_bcd     <= '0;
      o_dp      <= 1'b0;
      o_blank   <= 1'b1;
      o_frame   <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      idx     <= idx_n;
      act_val <= act_n;
      act_dp  <= act_dp_n;
      // A load coinciding with a transfer keeps the flag set for the new data.
      if (i_load) begin
        pend_val  <= i_value;
        pend_dp   <= i_dp;
        pend_flag <= 1'b1;
      end else if (xfer) begin
        pend_flag <= 1'b0;
      end
      o_sel   <= idx_n;
      o_bcd   <= digit;
      o_dp    <= act_dp_n[idx_n] & ~blank_n;
      o_blank <= blank_n;
      o_frame <= wrap;
    end
  end

endmodule
